// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and width defaults for the M-extension sequencer.
// Combinational definitions only; no latency.
// No flow control; consumed by the ALU decode and the sequencer.
package mdu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // SELECT codes shared with the single-cycle ALU decode
  localparam logic [4:0] SEL_MUL    = 5'b11000;
  localparam logic [4:0] SEL_MULH   = 5'b11001;
  localparam logic [4:0] SEL_MULHSU = 5'b11010;
  localparam logic [4:0] SEL_MULHU  = 5'b11011;
  localparam logic [4:0] SEL_DIV    = 5'b11100;
  localparam logic [4:0] SEL_REM    = 5'b11101;
  localparam logic [4:0] SEL_REMU   = 5'b11111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FIX    = 2'd2,
    FINISH = 2'd3
  } state_t;

  // 11110 is deliberately absent: it belongs to no M-extension op here
  function automatic logic sel_supported(input logic [4:0] sel);
    return sel inside {SEL_MUL, SEL_MULH, SEL_MULHSU, SEL_MULHU,
                       SEL_DIV, SEL_REM, SEL_REMU};
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the EX stage and the multi-cycle MDU.
// Pure wiring; no latency.
// STALL is the only backpressure: the pipeline holds operands while it is high.
interface mdu_sequencer_if #(
  parameter int XLEN = mdu_pkg::XLEN_DEFAULT
);
  logic            start;
  logic [4:0]      select;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic            kill;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  // EX-stage side
  modport master (
    output start, select, data1, data2, kill,
    input  stall, busy, done, result
  );

  // MDU side
  modport slave (
    input  start, select, data1, data2, kill,
    output stall, busy, done, result
  );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring-divide step.
// Purely combinational; zero latency.
// No flow control; the sequencer decides when the step result is registered.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] hi_i,    // product upper half / partial remainder
  input  logic [XLEN-1:0] lo_i,    // multiplier bits left / dividend-quotient
  input  logic [XLEN-1:0] opnd_i,  // multiplicand or divisor magnitude
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   add_sel;
  logic [XLEN:0]   shr;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Select between add-then-shift-right and shift-left-then-trial-subtract
  always_comb begin
    // Multiply: carry out of the add must survive the right shift
    sum     = {1'b0, hi_i} + {1'b0, opnd_i};
    add_sel = lo_i[0] ? sum : {1'b0, hi_i};
    // Divide: the shifted remainder can exceed XLEN bits before the subtract
    shr     = {hi_i, lo_i[XLEN-1]};
    ge      = (shr >= {1'b0, opnd_i});
    // When ge holds, the true difference is below the divisor and fits XLEN bits
    diff    = shr[XLEN-1:0] - opnd_i;
    if (is_div_i) begin
      hi_o = ge ? diff : shr[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = add_sel[XLEN:1];
      lo_o = {add_sel[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/MULH*/DIV/REM sequencer for the EX stage with registered RESULT.
// Normal ops: DONE 34 cycles after START; divide-by-zero/overflow: DONE 1 cycle after.
// Stalls the pipeline while working; KILL aborts without DONE, START ignored unless idle.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input logic              clk_i,
  input logic              rst_i,
  mdu_sequencer_if.slave   bus
);

  localparam int CW = $clog2(XLEN);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] opnd_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      op_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic            busy_q;
  logic            done_q;

  logic            accept;
  logic            req_div;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] fast_res;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_res;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  // Decode the incoming request: signs, magnitudes and the fast-path cases
  always_comb begin
    req_div  = bus.select[2];
    a_neg    = bus.data1[XLEN-1] &
               (bus.select inside {SEL_MUL, SEL_MULH, SEL_MULHSU, SEL_DIV, SEL_REM});
    b_neg    = bus.data2[XLEN-1] &
               (bus.select inside {SEL_MUL, SEL_MULH, SEL_DIV, SEL_REM});
    a_mag    = a_neg ? -bus.data1 : bus.data1;
    b_mag    = b_neg ? -bus.data2 : bus.data2;
    div_zero = req_div & (bus.data2 == '0);
    ovf      = (bus.select inside {SEL_DIV, SEL_REM}) &
               (bus.data1 == {1'b1, {(XLEN-1){1'b0}}}) & (bus.data2 == '1);
    if (div_zero) begin
      fast_res = (bus.select == SEL_DIV) ? '1 : bus.data1;
    end else begin
      fast_res = (bus.select == SEL_DIV) ? bus.data1 : '0;
    end
    accept   = (state_q == IDLE) & bus.start & sel_supported(bus.select) & ~bus.kill;
  end

  // Sign correction and result selection applied in FIX
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = (a_neg_q ^ b_neg_q) ? -prod : prod;
    quot_fix = (a_neg_q ^ b_neg_q) ? -lo_q : lo_q;
    rem_fix  = a_neg_q ? -hi_q : hi_q;
    case (op_q)
      SEL_MUL:                          fix_res = prod_fix[XLEN-1:0];
      SEL_MULH, SEL_MULHSU, SEL_MULHU:  fix_res = prod_fix[2*XLEN-1:XLEN];
      SEL_DIV:                          fix_res = quot_fix;
      default:                          fix_res = rem_fix;
    endcase
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q[2]),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opnd_i   (opnd_q),
    .hi_o     (step_hi),
    .lo_o     (step_lo)
  );

  // Sequencer FSM with counter, operand registers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q    <= bus.select;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            cnt_q   <= CW'(XLEN - 1);
            hi_q    <= '0;
            lo_q    <= req_div ? a_mag : b_mag;
            opnd_q  <= req_div ? b_mag : a_mag;
            if (div_zero | ovf) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= FINISH;
            end else begin
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.kill) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            hi_q <= step_hi;
            lo_q <= step_lo;
            if (cnt_q == '0) begin
              state_q <= FIX;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
        end
        FIX: begin
          busy_q <= 1'b0;
          if (bus.kill) begin
            state_q <= IDLE;
          end else begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state_q  <= FINISH;
          end
        end
        FINISH: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall  = accept | busy_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a cycle-timeline reference model.
// Model predicts STALL/BUSY/DONE/RESULT every cycle from arithmetic results.
// Literal expectations pin both the DUT and the model's arithmetic.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mdu_sequencer_if #(.XLEN(32)) bus();

  mdu_sequencer #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: a timeline of the op in flight
  int          cyc = 0;
  bit          live = 1'b0;
  int          busy_lo = 0;
  int          busy_hi = -1;
  int          done_at = -100;
  logic [31:0] pend = '0;
  logic [31:0] exp_res = '0;
  bit          chk_en = 1'b0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit ref_sup(input logic [4:0] sel);
    return (sel == 5'b11000) || (sel == 5'b11001) || (sel == 5'b11010) ||
           (sel == 5'b11011) || (sel == 5'b11100) || (sel == 5'b11101) ||
           (sel == 5'b11111);
  endfunction

  function automatic bit ref_fast(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    bit is_div_op;
    bit is_signed_div;
    is_div_op     = (sel == SEL_DIV) || (sel == SEL_REM) || (sel == SEL_REMU);
    is_signed_div = (sel == SEL_DIV) || (sel == SEL_REM);
    return (is_div_op && b == 32'h0) ||
           (is_signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Architectural result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ua;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (sel)
      SEL_MUL:    begin p = sa * sb; return p[31:0]; end
      SEL_MULH:   begin p = sa * sb; return p[63:32]; end
      SEL_MULHSU: begin p = sa * ub; return p[63:32]; end
      SEL_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      SEL_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      SEL_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      SEL_REMU: begin
        if (b == 32'h0) return a;
        p = ua % ub;
        return p[31:0];
      end
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_busy();
    return live && (cyc >= busy_lo) && (cyc <= busy_hi);
  endfunction

  function automatic bit m_done();
    return cyc == done_at;
  endfunction

  // Model update at each edge using the inputs of the cycle that is ending
  always @(posedge clk) begin
    if (rst) begin
      live    = 1'b0;
      done_at = -100;
      busy_hi = -1;
      exp_res = '0;
      chk_en  = 1'b1;
    end else if (m_busy() && bus.kill) begin
      live    = 1'b0;
      done_at = -100;
    end else if (!m_busy() && !m_done() && bus.start && ref_sup(bus.select) && !bus.kill) begin
      pend    = ref_result(bus.select, bus.data1, bus.data2);
      live    = 1'b1;
      busy_lo = cyc + 1;
      if (ref_fast(bus.select, bus.data1, bus.data2)) begin
        busy_hi = cyc;
        done_at = cyc + 1;
      end else begin
        busy_hi = cyc + 33;
        done_at = cyc + 34;
      end
    end
    cyc = cyc + 1;
    if (cyc == done_at) exp_res = pend;
  end

  // Per-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", bus.stall,
          32'(m_busy() || (!m_busy() && !m_done() && bus.start &&
                           ref_sup(bus.select) && !bus.kill)));
      chk("busy", bus.busy, 32'(m_busy()));
      chk("done", bus.done, 32'(m_done()));
      chk("result", bus.result, exp_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for DONE; leaves the bench one cycle after FINISH
  task automatic run_op(input string name, input logic [4:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int c0;
    bit seen;
    seen = 1'b0;
    chk({name, "_model"}, ref_result(sel, a, b), exp_r);
    bus.select = sel;
    bus.data1  = a;
    bus.data2  = b;
    bus.start  = 1'b1;
    c0 = cyc;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (bus.done) seen = 1'b1;
      else tick();
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({name, "_latency"}, 32'(cyc - c0), 32'(exp_lat));
      chk({name, "_result"}, bus.result, exp_r);
    end
    last_res = exp_r;
    tick();
  endtask

  int done_cnt;

  initial begin
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.select = 5'b0;
    bus.data1  = '0;
    bus.data2  = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("reset_stall",  bus.stall,  32'd0);
    chk("reset_busy",   bus.busy,   32'd0);
    chk("reset_done",   bus.done,   32'd0);
    chk("reset_result", bus.result, 32'd0);

    // Multiplies
    run_op("mul_7x6",     SEL_MUL,    32'd7,         32'd6,         32'h0000_002A, 34);
    run_op("mulh_m1",     SEL_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34);
    run_op("mulhu_max",   SEL_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu_m1",   SEL_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("mul_m1",      SEL_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34);
    run_op("mulhsu_min2", SEL_MULHSU, 32'h8000_0000, 32'd2,         32'hFFFF_FFFF, 34);

    // Divides
    run_op("div_m7_2",    SEL_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",    SEL_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("remu_m7_2",   SEL_REMU,   32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 34);
    run_op("div_7_m2",    SEL_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("rem_7_m2",    SEL_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 34);
    run_op("remu_big",    SEL_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);

    // Fast paths
    run_op("div_by0",     SEL_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem_by0",     SEL_REM,    32'd5,         32'd0,         32'h0000_0005, 1);
    run_op("remu_by0",    SEL_REMU,   32'd5,         32'd0,         32'h0000_0005, 1);
    run_op("div_ovf",     SEL_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",     SEL_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // START held through FINISH: ignored there, accepted again one cycle later
    bus.select = SEL_DIV;
    bus.data1  = 32'd9;
    bus.data2  = 32'd0;
    bus.start  = 1'b1;
    tick();
    chk("held_done_c1", bus.done, 32'd1);
    tick();
    chk("held_done_c2", bus.done, 32'd0);
    tick();
    chk("held_done_c3", bus.done, 32'd1);
    bus.start = 1'b0;
    last_res = 32'hFFFF_FFFF;
    tick();

    // KILL and START together in IDLE: not accepted
    bus.select = SEL_MUL;
    bus.data1  = 32'd3;
    bus.data2  = 32'd4;
    bus.start  = 1'b1;
    bus.kill   = 1'b1;
    #1;
    chk("killstart_stall", bus.stall, 32'd0);
    tick();
    bus.start = 1'b0;
    bus.kill  = 1'b0;
    chk("killstart_busy", bus.busy, 32'd0);

    // KILL in cycle 10 of a MUL, then MULHU 3x5 started in cycle 12
    bus.select = SEL_MUL;
    bus.data1  = 32'd7;
    bus.data2  = 32'd6;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    bus.kill = 1'b1;
    tick();
    bus.kill = 1'b0;
    chk("kill_busy",   bus.busy,   32'd0);
    chk("kill_result", bus.result, last_res);
    tick();
    run_op("mulhu_3x5", SEL_MULHU, 32'd3, 32'd5, 32'h0000_0000, 34);

    // Load a nonzero RESULT, then RESET in cycle 20 of another DIV
    run_op("div_100_7", SEL_DIV, 32'd100, 32'd7, 32'd14, 34);
    bus.select = SEL_DIV;
    bus.data1  = 32'd100;
    bus.data2  = 32'd7;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_stall",  bus.stall,  32'd0);
    chk("midrst_busy",   bus.busy,   32'd0);
    chk("midrst_done",   bus.done,   32'd0);
    chk("midrst_result", bus.result, 32'd0);

    // Unsupported SELECT: no STALL, never a DONE
    bus.select = 5'b11110;
    bus.start  = 1'b1;
    #1;
    chk("unsup_stall", bus.stall, 32'd0);
    tick();
    bus.start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    chk("no_done_after_rst", 32'(done_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
